// File: rtl/psram_qspi_responder.sv
// psram_qspi_responder: target-side model of the QSPI PSRAM link.
// Accepts SPI 35H (enter QPI), then QPI EBH quad reads and 38H quad writes
// against an internal byte array of 2^ADDR_W bytes.
// sck is sampled on clk_i; every shift and every sio_o update happens on a
// clk_i edge where sck has just gone high (a "rise event").
// Optional build macro: PSRAM_RESP_QPI_EXIT_EN. When it is defined, QPI
// command F5H leaves QPI mode. When it is not defined, F5H is reported
// as an unsupported command.
// DUMMY must be at least 1.
module psram_qspi_responder #(
  parameter int ADDR_W = 12,
  parameter int DUMMY  = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic [3:0] sio_oe,
  output logic       qpi_mode,
  output logic       cmd_err
);

  localparam int         DEPTH         = 1 << ADDR_W;
  localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
`ifdef PSRAM_RESP_QPI_EXIT_EN
  localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;
`endif
  localparam logic [7:0] DUMMY_LAST    = 8'(DUMMY - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_e;

  state_e              state_q, state_d;
  logic                sck_q;
  logic [7:0]          cnt_q, cnt_d;        // rise events seen in the current phase
  logic [6:0]          sh_q, sh_d;          // command bits / pending write high nibble
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_cmd_q, rd_cmd_d;  // 1: EBH read, 0: 38H write
  logic                half_q, half_d;      // next data nibble is the low nibble
  logic [3:0]          sio_o_q, sio_o_d;
  logic [3:0]          sio_oe_q, sio_oe_d;
  logic                qpi_q, qpi_d;
  logic                cmd_err_q, cmd_err_d;

  logic [7:0]          mem [DEPTH];
  logic                rise;
  logic [7:0]          cmd_byte;
  logic [7:0]          rd_byte;
  logic                mem_we;
  logic [7:0]          mem_wdata;

  assign rise     = sck & ~sck_q;
  assign sio_o    = sio_o_q;
  assign sio_oe   = sio_oe_q;
  assign qpi_mode = qpi_q;
  assign cmd_err  = cmd_err_q;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sck_q     <= 1'b0;
      cnt_q     <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      rd_cmd_q  <= 1'b0;
      half_q    <= 1'b0;
      sio_o_q   <= '0;
      sio_oe_q  <= '0;
      qpi_q     <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      rd_cmd_q  <= rd_cmd_d;
      half_q    <= half_d;
      sio_o_q   <= sio_o_d;
      sio_oe_q  <= sio_oe_d;
      qpi_q     <= qpi_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Byte array write port.
  // NOTE: the array has no reset; clearing every entry would prevent RAM
  // inference, and the contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
  end

  // Next-state and output decode; ce_n high overrides everything, including
  // a rise event that arrives in the same clk.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    rd_cmd_d  = rd_cmd_q;
    half_d    = half_q;
    sio_o_d   = sio_o_q;
    sio_oe_d  = sio_oe_q;
    qpi_d     = qpi_q;
    cmd_err_d = 1'b0;
    cmd_byte  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rd_byte   = mem[addr_q];

    if (ce_n) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      half_d   = 1'b0;
      sio_oe_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
          half_d  = 1'b0;
        end

        ST_CMD: begin
          if (rise) begin
            cnt_d = cnt_q + 8'd1;
            if (!qpi_q) begin
              // SPI mode: one bit per rise on sio_i[0], MSB first.
              cmd_byte = {sh_q, sio_i[0]};
              sh_d     = cmd_byte[6:0];
              if (cnt_q == 8'd7) begin
                cnt_d   = '0;
                state_d = ST_IGNORE;
                if (cmd_byte == CMD_QPI_ENTER) qpi_d     = 1'b1;
                else                           cmd_err_d = 1'b1;
              end
            end else begin
              // QPI mode: one nibble per rise, high nibble first.
              cmd_byte = {sh_q[3:0], sio_i};
              sh_d     = cmd_byte[6:0];
              if (cnt_q == 8'd1) begin
                cnt_d  = '0;
                addr_d = '0;
                if (cmd_byte == CMD_QREAD || cmd_byte == CMD_QWRITE) begin
                  state_d  = ST_ADDR;
                  rd_cmd_d = (cmd_byte == CMD_QREAD);
                end else if (cmd_byte == CMD_QPI_ENTER) begin
                  state_d = ST_IGNORE;
                end
`ifdef PSRAM_RESP_QPI_EXIT_EN
                else if (cmd_byte == CMD_QPI_EXIT) begin
                  qpi_d   = 1'b0;
                  state_d = ST_IGNORE;
                end
`endif
                else begin
                  cmd_err_d = 1'b1;
                  state_d   = ST_IGNORE;
                end
              end
            end
          end
        end

        ST_ADDR: begin
          if (rise) begin
            // Only the low ADDR_W bits of the 24-bit address are kept.
            addr_d = ADDR_W'({addr_q, sio_i});
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == 8'd5) begin
              cnt_d   = '0;
              half_d  = 1'b0;
              state_d = rd_cmd_q ? ST_DUMMY : ST_WDATA;
            end
          end
        end

        ST_DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == DUMMY_LAST) begin
              cnt_d    = '0;
              sio_oe_d = 4'hF;
              sio_o_d  = rd_byte[7:4];
              half_d   = 1'b1;
              state_d  = ST_RDATA;
            end
          end
        end

        ST_RDATA: begin
          if (rise) begin
            if (half_q) begin
              sio_o_d = rd_byte[3:0];
              addr_d  = addr_q + 1'b1;
              half_d  = 1'b0;
            end else begin
              sio_o_d = rd_byte[7:4];
              half_d  = 1'b1;
            end
          end
        end

        ST_WDATA: begin
          if (rise) begin
            if (!half_q) begin
              sh_d[3:0] = sio_i;
              half_d    = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_wdata = {sh_q[3:0], sio_i};
              addr_d    = addr_q + 1'b1;
              half_d    = 1'b0;
            end
          end
        end

        ST_IGNORE: sio_oe_d = '0;

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Self-checking bench for psram_qspi_responder.
// A byte-array model tracks what the device must hold; transaction tasks
// drive the pins and post the outputs the model predicts, and one compare
// process checks the DUT against those predictions every clk.
module tb_psram_qspi_responder;

  localparam int ADDR_W = 12;
  localparam int DUMMY  = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ce_n;
  logic [3:0] sio_i;
  logic [3:0] sio_o;
  logic [3:0] sio_oe;
  logic       qpi_mode;
  logic       cmd_err;

  always #5 clk = ~clk;

  psram_qspi_responder #(.ADDR_W(ADDR_W), .DUMMY(DUMMY)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .sck      (sck),
    .ce_n     (ce_n),
    .sio_i    (sio_i),
    .sio_o    (sio_o),
    .sio_oe   (sio_oe),
    .qpi_mode (qpi_mode),
    .cmd_err  (cmd_err)
  );

  // Reference model: array contents, which bytes are defined, and mode.
  logic [7:0] mem_m [DEPTH];
  bit         known [DEPTH];

  // Outputs the model expects after the most recent clk edge.
  logic       exp_qpi;
  logic       exp_err;
  logic [3:0] exp_oe;
  logic [3:0] exp_o;
  bit         exp_o_valid;
  bit         chk_en;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-clk comparison, sampled 2 ns after the active edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("qpi_mode", {7'b0, qpi_mode}, {7'b0, exp_qpi});
      check("cmd_err",  {7'b0, cmd_err},  {7'b0, exp_err});
      check("sio_oe",   {4'b0, sio_oe},   {4'b0, exp_oe});
      if (exp_oe == 4'hF && exp_o_valid)
        check("sio_o", {4'b0, sio_o}, {4'b0, exp_o});
    end
  end

  // One sck rising edge carrying nib; returns just before the sampling edge
  // so the caller can post what that edge must produce.
  task automatic rise(input logic [3:0] nib);
    @(negedge clk); sck = 1'b0; exp_err = 1'b0;
    @(negedge clk); sck = 1'b1; sio_i = nib;
  endtask

  task automatic start_txn();
    @(negedge clk); sck = 1'b0; exp_err = 1'b0; ce_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic stop_txn();
    @(negedge clk); sck = 1'b0; exp_err = 1'b0;
    @(negedge clk); ce_n = 1'b1; exp_oe = 4'h0; exp_o_valid = 1'b0;
    @(negedge clk);
  endtask

  // ce_n rises on the very edge that also carries an sck rise.
  task automatic stop_simul(input logic [3:0] nib);
    @(negedge clk); sck = 1'b0; exp_err = 1'b0;
    @(negedge clk); sck = 1'b1; sio_i = nib; ce_n = 1'b1;
    exp_oe = 4'h0; exp_o_valid = 1'b0;
    @(negedge clk); sck = 1'b0;
    @(negedge clk);
  endtask

  task automatic ignore_tail(input int n);
    for (int i = 0; i < n; i++) rise(4'($urandom));
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    start_txn();
    for (int i = 7; i >= 0; i--) rise({3'($urandom), b[i]});
    if (b == 8'h35) exp_qpi = 1'b1;
    else            exp_err = 1'b1;
    ignore_tail(3);
    stop_txn();
  endtask

  task automatic qpi_cmd(input logic [7:0] b);
    rise(b[7:4]);
    rise(b[3:0]);
    if (b == 8'hEB || b == 8'h38 || b == 8'h35) begin
      // accepted without error
    end
`ifdef PSRAM_RESP_QPI_EXIT_EN
    else if (b == 8'hF5) exp_qpi = 1'b0;
`endif
    else exp_err = 1'b1;
  endtask

  task automatic send_addr(input logic [23:0] a24);
    for (int i = 5; i >= 0; i--) rise(a24[i*4 +: 4]);
  endtask

  // abort_mode 0: clean end; 1: one stray nibble then ce_n;
  // 2: a stray high nibble, then ce_n together with the low nibble.
  task automatic qpi_write(input logic [23:0] a24, input byte_q_t data,
                           input int abort_mode, input logic [3:0] abort_nib);
    int a;
    a = int'(a24[ADDR_W-1:0]);
    start_txn();
    qpi_cmd(8'h38);
    send_addr(a24);
    foreach (data[i]) begin
      rise(data[i][7:4]);
      rise(data[i][3:0]);
      mem_m[a] = data[i];
      known[a] = 1'b1;
      a = (a + 1) % DEPTH;
    end
    if (abort_mode == 1) begin
      rise(abort_nib);
      stop_txn();
    end else if (abort_mode == 2) begin
      rise(abort_nib);
      stop_simul(4'($urandom));
    end else begin
      stop_txn();
    end
  endtask

  task automatic qpi_read(input logic [23:0] a24, input int n, output byte_q_t got);
    int a, idx;
    logic [3:0] hi;
    got = {};
    hi  = '0;
    a   = int'(a24[ADDR_W-1:0]);
    start_txn();
    qpi_cmd(8'hEB);
    send_addr(a24);
    for (int k = 0; k < 2 * n; k++) begin
      if (k == 0) begin
        for (int i = 0; i < DUMMY; i++) rise(4'($urandom));
        exp_oe = 4'hF;
      end else begin
        rise(4'($urandom));
      end
      idx         = (a + k / 2) % DEPTH;
      exp_o       = (k % 2 == 0) ? mem_m[idx][7:4] : mem_m[idx][3:0];
      exp_o_valid = known[idx];
      @(posedge clk); #2;
      if (k % 2 == 0) hi = sio_o;
      else            got.push_back({hi, sio_o});
    end
    stop_txn();
  endtask

  task automatic bad_cmd(input logic [7:0] b);
    start_txn();
    qpi_cmd(b);
    ignore_tail(4);
    stop_txn();
  endtask

  function automatic logic [11:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return 12'($urandom_range(0, 'h30));
    return 12'($urandom_range('hFC0, 'hFFF));
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] a24;
    byte_q_t     d, got;
    logic [7:0]  b;
    logic [7:0]  deadbeef [4];
    int          kind, n;

    deadbeef[0] = 8'hDE; deadbeef[1] = 8'hAD; deadbeef[2] = 8'hBE; deadbeef[3] = 8'hEF;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    rst = 1'b1; ce_n = 1'b1; sck = 1'b0; sio_i = '0;
    exp_qpi = 1'b0; exp_err = 1'b0; exp_oe = '0; exp_o = '0; exp_o_valid = 1'b0;
    chk_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset sio_o",    {4'b0, sio_o},    8'h00);
    check("reset sio_oe",   {4'b0, sio_oe},   8'h00);
    check("reset qpi_mode", {7'b0, qpi_mode}, 8'h00);
    check("reset cmd_err",  {7'b0, cmd_err},  8'h00);
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Enter QPI from SPI mode.
    spi_cmd(8'h35);
    check("qpi after 35H", {7'b0, qpi_mode}, 8'h01);

    // Fill both address windows used below with random bytes.
    d = {};
    for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
    a24 = 24'($urandom); a24[ADDR_W-1:0] = 12'h000;
    qpi_write(a24, d, 0, 4'h0);
    d = {};
    for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
    a24 = 24'($urandom); a24[ADDR_W-1:0] = 12'hFC0;
    qpi_write(a24, d, 0, 4'h0);

    // Write then read DE AD BE EF at 10h.
    qpi_write(24'h000010, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0, 4'h0);
    qpi_read(24'h000010, 4, got);
    for (int i = 0; i < 4; i++) check("deadbeef readback", got[i], deadbeef[i]);

    // Abort: 11h lands at 20h, the lone nibble 2 never reaches 21h.
    qpi_write(24'h000021, '{8'h5A}, 0, 4'h0);
    qpi_write(24'h000020, '{8'h11}, 1, 4'h2);
    qpi_read(24'h000020, 2, got);
    check("abort mem[20h]", got[0], 8'h11);
    check("abort mem[21h]", got[1], 8'h5A);
    qpi_read(24'h000021, 1, got);
    check("abort read 21h", got[0], 8'h5A);

    // Address wrap at the top of the array.
    qpi_write(24'h000FFF, '{8'hAA, 8'hBB}, 0, 4'h0);
    qpi_read(24'h000FFF, 2, got);
    check("wrap mem[FFFh]", got[0], 8'hAA);
    check("wrap mem[000h]", got[1], 8'hBB);

    // Unsupported QPI command, then a normal read.
    bad_cmd(8'h02);
    qpi_read(24'h000010, 1, got);
    check("read after bad cmd", got[0], 8'hDE);

    // QPI 35H is accepted silently.
    bad_cmd(8'h35);

    // ce_n rising together with a low nibble: 31h keeps its old value.
    qpi_write(24'h000030, '{8'h77}, 2, 4'h9);
    qpi_read(24'h000030, 2, got);
    check("simul ce_n mem[30h]", got[0], 8'h77);

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      a24 = 24'($urandom);
      a24[ADDR_W-1:0] = pick_addr();
      n = $urandom_range(1, 8);
      if (kind < 4) begin
        d = {};
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        qpi_write(a24, d, $urandom_range(0, 2), 4'($urandom));
      end else if (kind < 9) begin
        qpi_read(a24, n, got);
      end else begin
        do b = 8'($urandom);
        while (b == 8'hEB || b == 8'h38 || b == 8'h35 || b == 8'hF5);
        bad_cmd(b);
      end
    end

    // F5H: exits QPI when the option is built in, otherwise an error.
    bad_cmd(8'hF5);
`ifdef PSRAM_RESP_QPI_EXIT_EN
    check("qpi after F5H", {7'b0, qpi_mode}, 8'h00);
    spi_cmd(8'h35);
    check("qpi re-entered", {7'b0, qpi_mode}, 8'h01);
`else
    check("qpi after F5H", {7'b0, qpi_mode}, 8'h01);
`endif
    qpi_read(24'h000FFF, 2, got);
    check("final wrap read", got[1], 8'hBB);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
